// File: rtl/fetch_pkg.sv
// Shared opcodes, 2-bit counter encodings and RISC-V immediate extraction for the fetch stage.
package fetch_pkg;

  typedef logic [1:0] ctr_t;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t ST  = 2'b11;

  function automatic logic [31:0] b_imm(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table of 2-bit saturating counters plus the non-speculative global history.
module gshare_pht
  import fetch_pkg::*;
#(
  parameter int GHR_LEN = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [GHR_LEN-1:0] rd_index,
  output logic               rd_taken,
  input  logic               upd_valid,
  input  logic [GHR_LEN-1:0] upd_index,
  input  logic               upd_taken,
  output logic [GHR_LEN-1:0] ghr
);

  localparam int ENTRIES = 1 << GHR_LEN;

  ctr_t pht [ENTRIES];

  // Reads see the pre-update counter, so a same-cycle train never affects the prediction.
  assign rd_taken = pht[rd_index][1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= WNT;
      ghr <= '0;
    end else if (upd_valid) begin
      if (upd_taken && pht[upd_index] != ST)
        pht[upd_index] <= pht[upd_index] + 2'b01;
      else if (!upd_taken && pht[upd_index] != SNT)
        pht[upd_index] <= pht[upd_index] - 2'b01;
      ghr <= {ghr[GHR_LEN-2:0], upd_taken};
    end
  end

endmodule

// File: rtl/fetch_gshare.sv
// Fetch stage: PC generation, synchronous imem request, gshare prediction and taken-branch redirect.
// Define FETCH_JAL_REDIRECT_EN to also redirect on JAL at the response stage.
module fetch_gshare
  import fetch_pkg::*;
#(
  parameter int          GHR_LEN  = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  output logic               io_imem_en,
  output logic [31:0]        io_imem_addr,
  input  logic [31:0]        io_imem_rdata,
  input  logic               io_stall,
  output logic [31:0]        io_inst,
  output logic               io_inst_valid,
  output logic [31:0]        io_inst_pc,
  output logic               io_pred_taken,
  output logic [GHR_LEN-1:0] io_pred_index,
  input  logic               io_upd_valid,
  input  logic [GHR_LEN-1:0] io_upd_index,
  input  logic               io_upd_taken,
  input  logic               io_redirect_valid,
  input  logic [31:0]        io_redirect_pc
);

  logic [31:0]        fetch_pc, resp_pc, target;
  logic               resp_valid, is_br, pht_taken, taken;
  logic [6:0]         opcode;
  logic [GHR_LEN-1:0] ghr, idx;

  logic [31:0]        out_inst, out_pc;
  logic               out_valid, out_pred_taken;
  logic [GHR_LEN-1:0] out_pred_index;

  gshare_pht #(.GHR_LEN(GHR_LEN)) u_pht (
    .clock     (clock),
    .reset     (reset),
    .rd_index  (idx),
    .rd_taken  (pht_taken),
    .upd_valid (io_upd_valid),
    .upd_index (io_upd_index),
    .upd_taken (io_upd_taken),
    .ghr       (ghr)
  );

  always_comb begin
    opcode = io_imem_rdata[6:0];
    is_br  = resp_valid && (opcode == OPC_BRANCH);
    idx    = resp_pc[GHR_LEN+1:2] ^ ghr;
`ifdef FETCH_JAL_REDIRECT_EN
    taken  = (is_br && pht_taken) || (resp_valid && (opcode == OPC_JAL));
    target = resp_pc + ((opcode == OPC_JAL) ? j_imm(io_imem_rdata) : b_imm(io_imem_rdata));
`else
    taken  = is_br && pht_taken;
    target = resp_pc + b_imm(io_imem_rdata);
`endif
  end

  // A redirect must still launch a read so the new stream is not blocked by a stalled decoder.
  assign io_imem_en    = ~io_stall | io_redirect_valid;
  assign io_imem_addr  = fetch_pc;
  assign io_inst       = out_inst;
  assign io_inst_valid = out_valid;
  assign io_inst_pc    = out_pc;
  assign io_pred_taken = out_pred_taken;
  assign io_pred_index = out_pred_index;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc       <= RESET_PC;
      resp_pc        <= '0;
      resp_valid     <= 1'b0;
      out_valid      <= 1'b0;
      out_inst       <= '0;
      out_pc         <= '0;
      out_pred_taken <= 1'b0;
      out_pred_index <= '0;
    end else if (io_redirect_valid) begin
      fetch_pc   <= io_redirect_pc;
      resp_valid <= 1'b0;
      out_valid  <= 1'b0;
    end else if (!io_stall) begin
      out_valid      <= resp_valid;
      out_inst       <= io_imem_rdata;
      out_pc         <= resp_pc;
      out_pred_taken <= taken;
      out_pred_index <= idx;
      // The sequential read already in flight is wrong-path when we redirect to the target.
      resp_pc        <= fetch_pc;
      resp_valid     <= ~taken;
      fetch_pc       <= taken ? target : fetch_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_gshare.sv
// Self-checking bench for fetch_gshare: directed scenarios plus randomized traffic against a stream model.
module tb_fetch_gshare;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_imem_en;
  logic [31:0] io_imem_addr;
  logic [31:0] io_imem_rdata;
  logic        io_stall;
  logic [31:0] io_inst;
  logic        io_inst_valid;
  logic [31:0] io_inst_pc;
  logic        io_pred_taken;
  logic [7:0]  io_pred_index;
  logic        io_upd_valid;
  logic [7:0]  io_upd_index;
  logic        io_upd_taken;
  logic        io_redirect_valid;
  logic [31:0] io_redirect_pc;

  always #5 clock = ~clock;

  fetch_gshare dut (
    .clock             (clock),
    .reset             (reset),
    .io_imem_en        (io_imem_en),
    .io_imem_addr      (io_imem_addr),
    .io_imem_rdata     (io_imem_rdata),
    .io_stall          (io_stall),
    .io_inst           (io_inst),
    .io_inst_valid     (io_inst_valid),
    .io_inst_pc        (io_inst_pc),
    .io_pred_taken     (io_pred_taken),
    .io_pred_index     (io_pred_index),
    .io_upd_valid      (io_upd_valid),
    .io_upd_index      (io_upd_index),
    .io_upd_taken      (io_upd_taken),
    .io_redirect_valid (io_redirect_valid),
    .io_redirect_pc    (io_redirect_pc)
  );

  // Program image aliased every 256 bytes; kind 0 = ALU, 1 = BEQ, 2 = JAL.
  logic [31:0] prog [64];
  int          kind [64];
  int          offs [64];

  int          pht_m [256];
  int          snap  [256];
  logic [7:0]  ghr_m, ghr_snap;
  logic [31:0] expect_next;
  int          gap;
  int          vectors = 0;
  int          miscompares = 0;
  logic        jal_redirect;

  always @(posedge clock) if (io_imem_en) io_imem_rdata <= prog[io_imem_addr[7:2]];

  task check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_beq(input int off);
    logic [12:0] im;
    im = off[12:0];
    return {im[12], im[10:5], 13'd0, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input int off);
    logic [20:0] im;
    im = off[20:0];
    return {im[20], im[10:1], im[11], im[19:12], 5'd0, 7'b1101111};
  endfunction

  task set_word(input int w, input int k, input int off);
    kind[w] = k;
    offs[w] = off;
    if (k == 1)      prog[w] = enc_beq(off);
    else if (k == 2) prog[w] = enc_jal(off);
    else             prog[w] = 32'h0000_0013 | ($urandom() & 32'hFFFF_FF80);
  endtask

  task idle_inputs;
    io_stall          = 1'b0;
    io_redirect_valid = 1'b0;
    io_redirect_pc    = '0;
    io_upd_valid      = 1'b0;
    io_upd_index      = '0;
    io_upd_taken      = 1'b0;
  endtask

  task do_reset;
    idle_inputs();
    reset = 1'b0;
    #2;
    for (int i = 0; i < 256; i++) pht_m[i] = 1;
    ghr_m       = '0;
    expect_next = 32'h0;
    gap         = 0;
    check_output("rst_valid", io_inst_valid, 0);
    check_output("rst_addr",  io_imem_addr,  0);
    check_output("rst_inst",  io_inst,       0);
    check_output("rst_pc",    io_inst_pc,    0);
    check_output("rst_pred",  io_pred_taken, 0);
    check_output("rst_index", io_pred_index, 0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // One clock of the current inputs; the model advances and every visible effect is checked.
  task apply_stimulus;
    logic [31:0] p, redir_pc, prev_inst, prev_pc, prev_addr;
    logic        was_stall, was_redir, exp_en, pred, prev_valid, prev_pred;
    logic [7:0]  idx, prev_index;
    int          w, u;
    #1;
    exp_en = ~io_stall | io_redirect_valid;
    check_output("imem_en", io_imem_en, exp_en);
    prev_inst  = io_inst;   prev_pc   = io_inst_pc;    prev_addr  = io_imem_addr;
    prev_valid = io_inst_valid; prev_pred = io_pred_taken; prev_index = io_pred_index;
    was_stall = io_stall; was_redir = io_redirect_valid; redir_pc = io_redirect_pc;
    for (int i = 0; i < 256; i++) snap[i] = pht_m[i];
    ghr_snap = ghr_m;
    if (io_upd_valid) begin
      u = int'(io_upd_index);
      if (io_upd_taken) pht_m[u] = (pht_m[u] == 3) ? 3 : pht_m[u] + 1;
      else              pht_m[u] = (pht_m[u] == 0) ? 0 : pht_m[u] - 1;
      ghr_m = {ghr_m[6:0], io_upd_taken};
    end
    @(posedge clock);
    @(negedge clock);
    if (was_redir) begin
      check_output("redir_valid", io_inst_valid, 0);
      check_output("redir_addr",  io_imem_addr,  redir_pc);
      expect_next = redir_pc;
      gap = 0;
    end else if (was_stall) begin
      check_output("hold_inst",  io_inst,       prev_inst);
      check_output("hold_pc",    io_inst_pc,    prev_pc);
      check_output("hold_valid", io_inst_valid, prev_valid);
      check_output("hold_pred",  io_pred_taken, prev_pred);
      check_output("hold_index", io_pred_index, prev_index);
      check_output("hold_addr",  io_imem_addr,  prev_addr);
    end else if (io_inst_valid) begin
      p = expect_next;
      w = int'(p[7:2]);
      check_output("stream_pc",   io_inst_pc, p);
      check_output("stream_inst", io_inst,    prog[w]);
      idx  = p[9:2] ^ ghr_snap;
      pred = 1'b0;
      if (kind[w] == 1)      pred = (snap[idx] >= 2);
      else if (kind[w] == 2) pred = jal_redirect;
      check_output("stream_pred", io_pred_taken, pred);
      if (kind[w] == 1) check_output("stream_index", io_pred_index, idx);
      expect_next = pred ? p + offs[w] : p + 32'd4;
      gap = 0;
    end else begin
      gap++;
      check_output("bubble_limit", (gap < 2), 1);
    end
  endtask

  task wait_for_pc(input string tag, input logic [31:0] pc, input int budget);
    logic found;
    found = 1'b0;
    idle_inputs();
    for (int n = 0; n < budget && !found; n++) begin
      apply_stimulus();
      if (io_inst_valid && io_inst_pc == pc) found = 1'b1;
    end
    check_output(tag, found, 1);
  endtask

  task cycles_to_valid(output int n);
    n = 0;
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      apply_stimulus();
      n++;
      if (io_inst_valid) break;
    end
  endtask

  task redirect_to(input logic [31:0] pc);
    idle_inputs();
    io_redirect_valid = 1'b1;
    io_redirect_pc    = pc;
    apply_stimulus();
    idle_inputs();
  endtask

  task train(input logic [7:0] index, input logic tkn, input int times);
    for (int k = 0; k < times; k++) begin
      idle_inputs();
      io_upd_valid = 1'b1;
      io_upd_index = index;
      io_upd_taken = tkn;
      apply_stimulus();
    end
    idle_inputs();
  endtask

  task probe(input logic [31:0] pc, input logic [7:0] exp_idx, input logic exp_taken);
    set_word(int'(pc[7:2]), 1, 8);
    redirect_to(pc);
    wait_for_pc("probe_reach", pc, 6);
    check_output("probe_pred",  io_pred_taken, exp_taken);
    check_output("probe_index", io_pred_index, exp_idx);
    set_word(int'(pc[7:2]), 0, 0);
  endtask

  initial begin
    int n;
    logic [31:0] pc;
`ifdef FETCH_JAL_REDIRECT_EN
    jal_redirect = 1'b1;
`else
    jal_redirect = 1'b0;
`endif
    for (int w = 0; w < 64; w++) set_word(w, 0, 0);
    set_word(2, 1, 16);
    prog[2] = 32'h0000_0863;

    do_reset();
    check_output("boot_addr0", io_imem_addr, 32'h0);
    apply_stimulus();
    check_output("boot_addr4", io_imem_addr, 32'h4);
    check_output("boot_valid0", io_inst_valid, 0);
    apply_stimulus();
    check_output("boot_addr8", io_imem_addr, 32'h8);
    check_output("boot_valid1", io_inst_valid, 1);
    check_output("boot_pc0", io_inst_pc, 32'h0);
    apply_stimulus();
    apply_stimulus();
    check_output("beq_pc", io_inst_pc, 32'h8);
    check_output("beq_wnt_pred", io_pred_taken, 0);
    check_output("beq_wnt_index", io_pred_index, 8'd2);
    apply_stimulus();
    check_output("beq_fall_pc", io_inst_pc, 32'hC);

    // Two taken outcomes move history to 2'b11, so pc 8 then indexes entry 2 ^ 3 = 1.
    train(8'd1, 1'b1, 2);
    redirect_to(32'h0);
    wait_for_pc("beq_reach", 32'h8, 8);
    check_output("beq_taken_pred", io_pred_taken, 1);
    check_output("beq_taken_index", io_pred_index, 8'd1);
    cycles_to_valid(n);
    check_output("beq_bubble", n, 2);
    check_output("beq_target_pc", io_inst_pc, 32'h18);

    io_stall = 1'b1;
    for (int k = 0; k < 3; k++) apply_stimulus();
    idle_inputs();
    apply_stimulus();
    check_output("stall_resume_pc", io_inst_pc, 32'h1C);
    check_output("stall_resume_valid", io_inst_valid, 1);

    io_stall = 1'b1;
    io_redirect_valid = 1'b1;
    io_redirect_pc = 32'h100;
    apply_stimulus();
    check_output("rs_valid", io_inst_valid, 0);
    check_output("rs_addr", io_imem_addr, 32'h100);
    idle_inputs();
    apply_stimulus();
    check_output("rs_bubble", io_inst_valid, 0);
    apply_stimulus();
    check_output("rs_valid_pc", io_inst_pc, 32'h100);
    check_output("rs_valid_now", io_inst_valid, 1);

    train(8'd5, 1'b1, 4);
    probe({22'd0, 8'd5 ^ ghr_m, 2'b00}, 8'd5, 1'b1);
    train(8'd5, 1'b0, 1);
    probe({22'd0, 8'd5 ^ ghr_m, 2'b00}, 8'd5, 1'b1);
    train(8'd5, 1'b0, 3);
    probe(32'h3D4, 8'd5, 1'b0);

    set_word(16, 2, 32'h20);
    set_word(24, 0, 0);
    redirect_to(32'h40);
    wait_for_pc("jal_reach", 32'h40, 6);
    check_output("jal_pred", io_pred_taken, jal_redirect);
    cycles_to_valid(n);
    check_output("jal_next_pc", io_inst_pc, jal_redirect ? 32'h60 : 32'h44);
    check_output("jal_gap", n, jal_redirect ? 2 : 1);

    for (int w = 0; w < 64; w++) begin
      n = $urandom_range(0, 9);
      if (n < 4)      set_word(w, 1, $urandom_range(1, 8) * 4 * (($urandom() & 1) ? 1 : -1));
      else if (n < 5) set_word(w, 2, $urandom_range(1, 16) * 4 * (($urandom() & 1) ? 1 : -1));
      else            set_word(w, 0, 0);
    end
    redirect_to(32'h0);
    for (int c = 0; c < 1600; c++) begin
      if (c == 800) do_reset();
      io_stall          = ($urandom_range(0, 4) == 0);
      io_redirect_valid = ($urandom_range(0, 19) == 0);
      pc                = 32'($urandom_range(0, 255)) << 2;
      io_redirect_pc    = pc;
      io_upd_valid      = ($urandom_range(0, 2) == 0);
      io_upd_index      = ($urandom() & 1) ? (io_inst_pc[9:2] ^ ghr_m) : 8'($urandom());
      io_upd_taken      = ($urandom_range(0, 3) != 0);
      apply_stimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
